touch_adc_responder: RTL and testbench
======================================

Name: touch_adc_responder

Overview:
- Synthesizable responder for the 4-wire touch-panel ADC serial interface: the device end of the existing touch-screen controller's link.
- Acts as a DCLK-slave. It captures an 8-bit control byte on DIN, raises BUSY, then shifts a 12-bit or 8-bit result on DOUT. It also drives an active-low PENIRQ.
- Used on-board and in simulation as a stand-in for the panel ADC. Position samples come from switches or bench stimulus, so the controller and CPU touch path can be exercised without a panel.

Parameters:
- SYNC_STAGES, 2, flops in the synchronizer on tp_cs, tp_dclk, tp_din (≥2).
- X_CHANNEL, 3'b101, A2..A0 code that returns x_sample.
- Y_CHANNEL, 3'b001, A2..A0 code that returns y_sample.

Ports:
- clk  input  1  system clock; all logic runs in this domain.
- reset  input  1  asynchronous, active-high reset.
- tp_cs  input  1  chip select from the controller, active low.
- tp_dclk  input  1  serial clock from the controller.
- tp_din  input  1  serial command data, sampled on DCLK rising edges.
- tp_dout  output  1  serial result data, changes on DCLK falling edges.
- tp_busy  output  1  conversion-busy indicator.
- tp_penirq  output  1  pen interrupt, active low.
- pen_down  input  1  panel is touched.
- x_sample  input  12  X position value.
- y_sample  input  12  Y position value.
- last_cmd  output  8  most recently latched control byte.
- cmd_valid  output  1  one-clk pulse when a control byte is latched.

Behaviour:
- Reset values: tp_dout=0, tp_busy=0, last_cmd=8'h00, cmd_valid=0, state=IDLE, irq_en=1, so tp_penirq=~pen_down.
- Input synchronization and edge detection:
  - tp_cs, tp_dclk and tp_din each pass through SYNC_STAGES flops.
  - DCLK rise/fall are detected from the last two synchronized samples.
  - The response lands SYNC_STAGES+1 clk after a pin edge.
  - Supported DCLK: high and low phases each ≥4 clk.
- Chip select: synchronized tp_cs=1 forces state=IDLE, tp_busy=0, tp_dout=0 and bit_cnt=0 on the next clk, from any state.
- States:
  - IDLE: on each DCLK rise with cs low, if din=1 (start bit) shift it into cmd_sr, set bit_cnt=1 and go to CMD. din=0 is ignored, so leading zeros are allowed.
  - CMD: on each DCLK rise shift din into cmd_sr (MSB first) and increment bit_cnt. At the 8th bit:
    - latch last_cmd and pulse cmd_valid for 1 clk;
    - irq_en ← ~cmd[0] (PD0);
    - go to BUSY_WAIT.
  - BUSY_WAIT: on the next DCLK fall:
    - tp_busy=1;
    - snapshot result: channel cmd[6:4]==X_CHANNEL selects x_sample, ==Y_CHANNEL selects y_sample, any other channel gives 12'h000;
    - mode cmd[3]=1 (8-bit) loads sample[11:4] left-aligned, cmd[3]=0 loads all 12 bits;
    - n = 8 or 12 respectively; go to DATA.
  - DATA: on each DCLK fall shift out one bit:
    - the first fall clears tp_busy and drives the MSB;
    - the following falls drive the next bits;
    - the fall after the n-th bit drives tp_dout=0 and returns to IDLE.
- During BUSY_WAIT and DATA, din is ignored (no 16-clock overlapped conversions).
- The snapshot isolates the output: changes on x_sample/y_sample after the BUSY rise do not affect the word being shifted.
- tp_penirq = ~(pen_down & irq_en & state==IDLE), registered. It is forced high throughout any transaction.
- cmd[2] (SER/DFR) and cmd[1] (PD1) are stored in last_cmd but have no other effect.
- Asserting reset mid-transaction returns to reset values at once; the next transaction needs a fresh start bit.

Test Plan:
- Reset, then pen_down=1, cs high → tp_busy=0, tp_dout=0, tp_penirq=0 within 3 clk; cmd_valid never pulses.
- x_sample=12'hA5C, send 0xD0 (X channel, 12-bit) → cmd_valid pulses once, last_cmd=8'hD0; busy high for exactly one DCLK period; DOUT reads 1010_0101_1100, then 0; state IDLE.
- y_sample=12'h3F1, send 0x98 (Y channel, 8-bit) → DOUT reads 0011_1111 (8 bits), then 0; return to IDLE after the 8th data fall.
- Send 0x00,0x00, then 0x90 with y_sample=12'h123 → leading zeros ignored; result 12'h123. Change y_sample to 12'hFFF after BUSY rises → output still 12'h123.
- Send 0xD1 with pen_down=1 → tp_penirq high during the transaction and stays high afterwards (irq_en=0). Then send 0xD0 → tp_penirq low again once IDLE.
- Raise tp_cs after 5 data bits of 0xD0 → busy=0, dout=0 within 3 clk. The next 0xD0 transaction is correct, with no residual bits.

Source files
------------

// File: rtl/touch_adc_responder.sv
// Device end of the 4-wire touch-panel ADC link. It takes a control byte on DIN,
// answers with BUSY and a 12- or 8-bit sample on DOUT, and drives PENIRQ.
module touch_adc_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] X_CHANNEL   = 3'b101,
    parameter logic [2:0] Y_CHANNEL   = 3'b001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tp_cs,
    input  logic        tp_dclk,
    input  logic        tp_din,
    output logic        tp_dout,
    output logic        tp_busy,
    output logic        tp_penirq,
    input  logic        pen_down,
    input  logic [11:0] x_sample,
    input  logic [11:0] y_sample,
    output logic [7:0]  last_cmd,
    output logic        cmd_valid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CMD       = 2'd1,
        BUSY_WAIT = 2'd2,
        DATA      = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_dclk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_dclk_prev;

    state_t      r_state;
    logic [6:0]  r_cmd_sr;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  r_nbits;
    logic [11:0] r_shift;
    logic        r_irq_en;
    logic        r_dout;
    logic        r_busy;
    logic        r_penirq;
    logic [7:0]  r_last_cmd;
    logic        r_cmd_valid;

    logic        w_cs;
    logic        w_dclk;
    logic        w_din;
    logic        w_rise;
    logic        w_fall;
    logic [7:0]  w_cmd_next;
    logic [11:0] w_sample;
    logic [11:0] w_snapshot;

    // The extra r_dclk_prev flop puts the response SYNC_STAGES+1 clk after a pin edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_sync   <= '1;
            r_dclk_sync <= '0;
            r_din_sync  <= '0;
            r_dclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], tp_cs};
            r_dclk_sync <= {r_dclk_sync[SYNC_STAGES-2:0], tp_dclk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], tp_din};
            r_dclk_prev <= r_dclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_dclk     = r_dclk_sync[SYNC_STAGES-1];
    assign w_din      = r_din_sync[SYNC_STAGES-1];
    assign w_rise     = w_dclk & ~r_dclk_prev;
    assign w_fall     = ~w_dclk & r_dclk_prev;
    assign w_cmd_next = {r_cmd_sr, w_din};

    always_comb begin
        w_sample = 12'h000;
        if (r_last_cmd[6:4] == X_CHANNEL) begin
            w_sample = x_sample;
        end else if (r_last_cmd[6:4] == Y_CHANNEL) begin
            w_sample = y_sample;
        end
        w_snapshot = r_last_cmd[3] ? {w_sample[11:4], 4'h0} : w_sample;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmd_sr    <= 7'h00;
            r_bit_cnt   <= 4'd0;
            r_nbits     <= 4'd12;
            r_shift     <= 12'h000;
            r_irq_en    <= 1'b1;
            r_dout      <= 1'b0;
            r_busy      <= 1'b0;
            r_penirq    <= 1'b1;
            r_last_cmd  <= 8'h00;
            r_cmd_valid <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_penirq    <= ~(pen_down & r_irq_en & (r_state == IDLE));
            if (w_cs) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_dout    <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // Zeros ahead of the start bit are padding and are skipped.
                        if (w_rise && w_din) begin
                            r_cmd_sr  <= 7'h01;
                            r_bit_cnt <= 4'd1;
                            r_state   <= CMD;
                        end
                    end
                    CMD: begin
                        if (w_rise) begin
                            r_cmd_sr  <= w_cmd_next[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_last_cmd  <= w_cmd_next;
                                r_cmd_valid <= 1'b1;
                                r_irq_en    <= ~w_din;
                                r_bit_cnt   <= 4'd0;
                                r_state     <= BUSY_WAIT;
                            end
                        end
                    end
                    BUSY_WAIT: begin
                        if (w_fall) begin
                            r_busy    <= 1'b1;
                            r_shift   <= w_snapshot;
                            r_nbits   <= r_last_cmd[3] ? 4'd8 : 4'd12;
                            r_bit_cnt <= 4'd0;
                            r_state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (w_fall) begin
                            r_busy <= 1'b0;
                            if (r_bit_cnt != r_nbits) begin
                                r_dout    <= r_shift[11];
                                r_shift   <= {r_shift[10:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end else begin
                                r_dout    <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign tp_dout   = r_dout;
    assign tp_busy   = r_busy;
    assign tp_penirq = r_penirq;
    assign last_cmd  = r_last_cmd;
    assign cmd_valid = r_cmd_valid;

endmodule

// File: tb/tb_touch_adc_responder.sv
// Bench for touch_adc_responder: a DCLK master that sends control bytes and
// checks BUSY/DOUT against a queue of expected result bits.
module tb_touch_adc_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        tp_cs;
    logic        tp_dclk;
    logic        tp_din;
    logic        tp_dout;
    logic        tp_busy;
    logic        tp_penirq;
    logic        pen_down;
    logic [11:0] x_sample;
    logic [11:0] y_sample;
    logic [7:0]  last_cmd;
    logic        cmd_valid;

    int   n_vec = 0;
    int   n_err = 0;
    int   cv_cnt = 0;
    logic exp_q[$];

    touch_adc_responder dut (
        .clk       (clk),
        .reset     (reset),
        .tp_cs     (tp_cs),
        .tp_dclk   (tp_dclk),
        .tp_din    (tp_din),
        .tp_dout   (tp_dout),
        .tp_busy   (tp_busy),
        .tp_penirq (tp_penirq),
        .pen_down  (pen_down),
        .x_sample  (x_sample),
        .y_sample  (y_sample),
        .last_cmd  (last_cmd),
        .cmd_valid (cmd_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_valid === 1'b1) cv_cnt++;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One frame: lead zero clocks, 8 command bits, busy clock, n data clocks, one idle clock.
    task automatic xfer(input string name, input logic [7:0] cmd, input logic [11:0] word,
                        input int n, input int lead, input int abort_at,
                        input logic chg_y, input logic irq_end);
        int   last;
        logic eb;
        last = 10 + n;
        for (int i = 0; i < n; i++) exp_q.push_back(word[11-i]);
        tp_dclk = 1'b0;
        tp_din  = 1'b0;
        tp_cs   = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int z = 0; z < lead; z++) begin
            tp_din = 1'b0;
            repeat (HALF) @(negedge clk);
            tp_dclk = 1'b1;
            repeat (HALF) @(negedge clk);
            tp_dclk = 1'b0;
        end
        for (int c = 1; c <= last; c++) begin
            tp_din = (c <= 8) ? cmd[8-c] : 1'b0;
            repeat (HALF) @(negedge clk);
            n_vec++;
            eb = (c == 9);
            if (tp_busy !== eb) begin
                n_err++;
                $display("FAIL %s busy@clk%0d: got %b want %b", name, c, tp_busy, eb);
            end
            if (c == 9 && chg_y) y_sample = 12'hFFF;
            if (c == 5) begin
                n_vec++;
                if (tp_penirq !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s penirq_in_frame: got %b want 1", name, tp_penirq);
                end
            end
            if (c >= 10 && c <= 9 + n) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s scoreboard_empty@clk%0d: got dout %b want queued bit", name, c, tp_dout);
                end else begin
                    eb = exp_q.pop_front();
                    if (tp_dout !== eb) begin
                        n_err++;
                        $display("FAIL %s dout_bit%0d: got %b want %b", name, c - 10, tp_dout, eb);
                    end
                end
            end
            if (c == last) begin
                n_vec += 2;
                if (tp_dout !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s dout_after: got %b want 0", name, tp_dout);
                end
                if (tp_penirq !== irq_end) begin
                    n_err++;
                    $display("FAIL %s penirq_after: got %b want %b", name, tp_penirq, irq_end);
                end
            end
            if (abort_at > 0 && c == 9 + abort_at) begin
                tp_cs = 1'b1;
                repeat (3) @(negedge clk);
                n_vec += 2;
                if (tp_busy !== 1'b0 || tp_dout !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s abort: got busy=%b dout=%b want 0 0", name, tp_busy, tp_dout);
                end
                exp_q.delete();
                repeat (HALF) @(negedge clk);
                return;
            end
            tp_dclk = 1'b1;
            repeat (HALF) @(negedge clk);
            tp_dclk = 1'b0;
        end
        tp_cs  = 1'b1;
        tp_din = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_cmd(input string name, input logic [7:0] cmd, input int cv_before);
        n_vec += 2;
        if (cv_cnt - cv_before !== 1) begin
            n_err++;
            $display("FAIL %s cmd_valid_count: got %0d want 1", name, cv_cnt - cv_before);
        end
        if (last_cmd !== cmd) begin
            n_err++;
            $display("FAIL %s last_cmd: got %h want %h", name, last_cmd, cmd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tp_cs = 1'b1; tp_dclk = 1'b0; tp_din = 1'b0;
        pen_down = 1'b1; x_sample = 12'h000; y_sample = 12'h000;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 4;
        if (tp_busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", tp_busy); end
        if (tp_dout !== 1'b0)   begin n_err++; $display("FAIL reset_dout: got %b want 0", tp_dout); end
        if (tp_penirq !== 1'b0) begin n_err++; $display("FAIL reset_penirq: got %b want 0", tp_penirq); end
        if (last_cmd !== 8'h00) begin n_err++; $display("FAIL reset_last_cmd: got %h want 00", last_cmd); end
        for (int i = 0; i < 10; i++) begin
            tp_din = 1'b1;
            repeat (HALF) @(negedge clk);
            tp_dclk = ~tp_dclk;
        end
        tp_dclk = 1'b0; tp_din = 1'b0;
        repeat (HALF) @(negedge clk);
        n_vec += 2;
        if (cv_cnt !== 0)     begin n_err++; $display("FAIL cs_high_cmd_valid: got %0d want 0", cv_cnt); end
        if (tp_busy !== 1'b0) begin n_err++; $display("FAIL cs_high_busy: got %b want 0", tp_busy); end
    endtask

    task automatic test_x12();
        int cv0 = cv_cnt;
        x_sample = 12'hA5C;
        xfer("x12", 8'hD0, 12'hA5C, 12, 0, 0, 1'b0, 1'b0);
        check_cmd("x12", 8'hD0, cv0);
    endtask

    task automatic test_y8();
        int cv0 = cv_cnt;
        y_sample = 12'h3F1;
        xfer("y8", 8'h98, 12'h3F0, 8, 0, 0, 1'b0, 1'b0);
        check_cmd("y8", 8'h98, cv0);
    endtask

    task automatic test_lead_zeros_snapshot();
        int cv0 = cv_cnt;
        y_sample = 12'h123;
        xfer("lead0", 8'h90, 12'h123, 12, 16, 0, 1'b1, 1'b0);
        check_cmd("lead0", 8'h90, cv0);
    endtask

    task automatic test_other_channel();
        int cv0 = cv_cnt;
        x_sample = 12'hFFF; y_sample = 12'hFFF;
        xfer("chan010", 8'hA0, 12'h000, 12, 0, 0, 1'b0, 1'b0);
        check_cmd("chan010", 8'hA0, cv0);
    endtask

    task automatic test_penirq();
        int cv0 = cv_cnt;
        x_sample = 12'hA5C;
        xfer("pd0_set", 8'hD1, 12'hA5C, 12, 0, 0, 1'b0, 1'b1);
        check_cmd("pd0_set", 8'hD1, cv0);
        repeat (20) @(negedge clk);
        n_vec++;
        if (tp_penirq !== 1'b1) begin n_err++; $display("FAIL penirq_held: got %b want 1", tp_penirq); end
        cv0 = cv_cnt;
        xfer("pd0_clr", 8'hD0, 12'hA5C, 12, 0, 0, 1'b0, 1'b0);
        check_cmd("pd0_clr", 8'hD0, cv0);
    endtask

    task automatic test_back_to_back();
        int cv0 = cv_cnt;
        x_sample = 12'hFFF;
        xfer("abort", 8'hD0, 12'hFFF, 12, 0, 5, 1'b0, 1'b0);
        check_cmd("abort", 8'hD0, cv0);
        x_sample = 12'hA5C;
        cv0 = cv_cnt;
        xfer("after_abort", 8'hD0, 12'hA5C, 12, 0, 0, 1'b0, 1'b0);
        check_cmd("after_abort", 8'hD0, cv0);
    endtask

    initial begin
        test_reset();
        test_x12();
        test_y8();
        test_lead_zeros_snapshot();
        test_other_channel();
        test_penirq();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
